// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba multiplier IP: default widths, loader
// state encoding and the words-per-operand helper.
package karatsuba_pkg;

  localparam int unsigned KARATSUBA_DATA_WIDTH = 8;
  localparam int unsigned KARATSUBA_OP_WIDTH   = 32;

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } loader_state_t;

  function automatic int unsigned words_per_op(input int unsigned op_width,
                                               input int unsigned data_width);
    return op_width / data_width;
  endfunction

endpackage

// File: rtl/karatsuba_word_packer.sv
// WORDS-slot operand register; writes one DATA_WIDTH word per load into the lane
// chosen by i_slot. KARATSUBA_LOADER_MSW_FIRST_EN makes slot 0 the top lane.
module karatsuba_word_packer
  import karatsuba_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KARATSUBA_DATA_WIDTH,
  parameter int unsigned WORDS      = 4,
  localparam int unsigned SW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load_en,
  input  logic [SW-1:0]               i_slot,
  input  logic [DATA_WIDTH-1:0]       i_word,
  output logic [WORDS*DATA_WIDTH-1:0] o_op
);

  logic [WORDS*DATA_WIDTH-1:0] r_op;

  function automatic int unsigned lane(input int unsigned slot);
`ifdef KARATSUBA_LOADER_MSW_FIRST_EN
    return WORDS - 1 - slot;
`else
    return slot;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op <= '0;
    end else if (i_load_en) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (32'(i_slot) == k) begin
          r_op[lane(k)*DATA_WIDTH +: DATA_WIDTH] <= i_word;
        end
      end
    end
  end

  assign o_op = r_op;

endmodule

// File: rtl/karatsuba_operand_loader.sv
// Pops FIFO words into operand A then B and presents the pair over valid/ready.
// Build option: KARATSUBA_LOADER_MSW_FIRST_EN (most-significant word first).
module karatsuba_operand_loader
  import karatsuba_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = KARATSUBA_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = KARATSUBA_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic [OP_WIDTH-1:0]   op_a,
  output logic [OP_WIDTH-1:0]   op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  busy
);

  localparam int unsigned WORDS = words_per_op(OP_WIDTH, DATA_WIDTH);
  localparam int unsigned SLOTS = 2 * WORDS;
  localparam int unsigned CW    = $clog2(SLOTS + 1);
  localparam int unsigned SW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
  localparam logic [CW-1:0] LAST_C  = CW'(SLOTS - 1);
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  generate
    if ((OP_WIDTH % DATA_WIDTH) != 0 || OP_WIDTH < DATA_WIDTH) begin : g_bad_width
      $error("OP_WIDTH must be a non-zero integer multiple of DATA_WIDTH");
    end
  endgenerate

  loader_state_t r_state;
  logic [CW-1:0] r_ic;
  logic [CW-1:0] r_cc;
  logic          r_rd_pend;
  logic          r_op_valid;

  logic          w_r_en;
  logic          w_cap_a;
  logic          w_load_a;
  logic          w_load_b;
  logic [SW-1:0] w_slot;

  assign w_r_en   = rst && (r_state == LOAD) && !fifo_empty && (r_ic < SLOTS_C);
  assign w_cap_a  = r_cc < WORDS_C;
  assign w_load_a = r_rd_pend && w_cap_a;
  assign w_load_b = r_rd_pend && !w_cap_a;
  assign w_slot   = SW'(w_cap_a ? r_cc : r_cc - WORDS_C);

  // The last read is issued with ic reaching SLOTS and captured on the edge that
  // enters PRESENT, so rd_pend is never set while presenting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= LOAD;
      r_ic       <= '0;
      r_cc       <= '0;
      r_rd_pend  <= 1'b0;
      r_op_valid <= 1'b0;
    end else begin
      r_rd_pend <= w_r_en;
      if (w_r_en) begin
        r_ic <= r_ic + 1'b1;
      end
      case (r_state)
        LOAD: begin
          if (r_rd_pend) begin
            r_cc <= r_cc + 1'b1;
            if (r_cc == LAST_C) begin
              r_state    <= PRESENT;
              r_op_valid <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (op_ready) begin
            r_state    <= LOAD;
            r_ic       <= '0;
            r_cc       <= '0;
            r_op_valid <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  karatsuba_word_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS)
  ) u_pack_a (
    .clk      (clk),
    .rst      (rst),
    .i_load_en(w_load_a),
    .i_slot   (w_slot),
    .i_word   (fifo_data),
    .o_op     (op_a)
  );

  karatsuba_word_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS)
  ) u_pack_b (
    .clk      (clk),
    .rst      (rst),
    .i_load_en(w_load_b),
    .i_slot   (w_slot),
    .i_word   (fifo_data),
    .o_op     (op_b)
  );

  assign fifo_r_en = w_r_en;
  assign op_valid  = r_op_valid;
  assign busy      = (r_state == LOAD) && (r_ic != '0);

endmodule

// File: tb/tb_karatsuba_operand_loader.sv
// Bench for karatsuba_operand_loader at DATA_WIDTH=8, OP_WIDTH=32 with a FIFO model
// and a pair scoreboard; honours KARATSUBA_LOADER_MSW_FIRST_EN for expected values.
module tb_karatsuba_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_r_en;
  logic [7:0]  fifo_data = '0;
  logic        fifo_empty;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        busy;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  typedef struct {
    logic [7:0] w [8];
    pair_t      exp;
  } vec_t;

  logic [7:0]  mem [0:255];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;
  int          n_vec  = 0;
  int          n_err  = 0;
  pair_t       exp_q[$];
  pair_t       mon_e;
  bit          seen = 1'b0;
  vec_t        tbl [6];

  karatsuba_operand_loader #(
    .DATA_WIDTH(8),
    .OP_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_r_en (fifo_r_en),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after an accepted read
  assign fifo_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_idx % 256];
      rd_idx    <= rd_idx + 1;
    end
  end

  function automatic logic [31:0] ref_pack(input logic [7:0] w0, w1, w2, w3);
`ifdef KARATSUBA_LOADER_MSW_FIRST_EN
    return {w0, w1, w2, w3};
`else
    return {w3, w2, w1, w0};
`endif
  endfunction

  function automatic pair_t ref_pair(input logic [7:0] w [8]);
    pair_t p;
    p.a = ref_pack(w[0], w[1], w[2], w[3]);
    p.b = ref_pack(w[4], w[5], w[6], w[7]);
    return p;
  endfunction

  function automatic vec_t mk_vec(input logic [7:0] base);
    vec_t v;
    for (int k = 0; k < 8; k++) v.w[k] = base + 8'(k);
    v.exp = ref_pair(v.w);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_idx % 256] = w;
    wr_idx++;
  endtask

  task automatic push_vec(input vec_t v);
    for (int k = 0; k < 8; k++) push(v.w[k]);
    exp_q.push_back(v.exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!op_valid && n < 40);
    if (!op_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: op_valid still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  // Scoreboard: one expected pair consumed per op_valid assertion
  always @(negedge clk) begin
    if (!op_valid) begin
      seen <= 1'b0;
    end else if (!seen) begin
      seen <= 1'b1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pair: got op_a=0x%0h op_b=0x%0h, required no pair", op_a, op_b);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_op_a", op_a, mon_e.a);
        check("sb_op_b", op_b, mon_e.b);
      end
    end
  end

  initial begin
    logic [10:0] ren_m, val_m, busy_m;
    vec_t        v1, sv, nv, rv;
    int          bad;
    int          n;

    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 8; k++) begin
        case (p)
          0:       tbl[p].w[k] = 8'(1 + k);
          1:       tbl[p].w[k] = 8'(9 + k);
          2:       tbl[p].w[k] = 8'hFF;
          3:       tbl[p].w[k] = 8'h00;
          4:       tbl[p].w[k] = (k % 2 == 1) ? 8'h5A : 8'hA5;
          default: tbl[p].w[k] = 8'($urandom);
        endcase
      end
      tbl[p].exp = ref_pair(tbl[p].w);
    end

    // Reset: words queued in the FIFO must not be read while rst is low
    op_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v1 = mk_vec(8'h01);
    push_vec(v1);
    @(negedge clk);
    check("rst_r_en",  32'(fifo_r_en), 32'd0);
    check("rst_valid", 32'(op_valid),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_op_a",  op_a,           32'd0);
    check("rst_op_b",  op_b,           32'd0);

    // Back-to-back pair: reads in cycles 0..7, op_valid only in cycle 9
    step();
    rst = 1'b1;
    ren_m = '0; val_m = '0; busy_m = '0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      ren_m[c]  = fifo_r_en;
      val_m[c]  = op_valid;
      busy_m[c] = busy;
    end
    check("b2b_r_en_cycles",  32'(ren_m),  32'h0FF);
    check("b2b_valid_cycles", 32'(val_m),  32'h200);
    check("b2b_busy_cycles",  32'(busy_m), 32'h1FE);

    // Empty gap after 3 words: no reads, no pair, partial words kept
    step();
    for (int k = 0; k < 3; k++) push(v1.w[k]);
    repeat (4) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fifo_r_en || op_valid) bad++;
    end
    check("gap_quiet", 32'(bad),  32'd0);
    check("gap_busy",  32'(busy), 32'd1);
    step();
    for (int k = 3; k < 8; k++) push(v1.w[k]);
    exp_q.push_back(v1.exp);
    wait_valid("gap");
    @(negedge clk);
    check("gap_valid_drop", 32'(op_valid), 32'd0);

    // Stall in PRESENT with more words waiting in the FIFO
    step();
    op_ready = 1'b0;
    sv = mk_vec(8'h21);
    nv = mk_vec(8'h29);
    push_vec(sv);
    for (int k = 0; k < 4; k++) push(nv.w[k]);
    wait_valid("stall");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!op_valid || fifo_r_en || op_a !== sv.exp.a || op_b !== sv.exp.b) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    step();
    op_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_at_accept", 32'(op_valid), 32'd1);
    @(negedge clk);
    check("stall_release", 32'(op_valid), 32'd0);
    step();
    for (int k = 4; k < 8; k++) push(nv.w[k]);
    exp_q.push_back(nv.exp);
    wait_valid("after_stall");

    // Reset after 3 captures discards the partial words
    step();
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_op_a", op_a,      32'd0);
    rv = mk_vec(8'h11);
    step();
    push_vec(rv);
    wait_valid("post_rst");

    // Table: contiguous pairs including 0x01..0x10 across a handshake
    step();
    for (int p = 0; p < 6; p++) push_vec(tbl[p]);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("sb_drained",     32'(exp_q.size()), 32'd0);
    check("words_consumed", 32'(rd_idx),       32'(wr_idx));
    check("final_busy",     32'(busy),         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
